// File: rtl/sap_pkg.sv
// Shared SAP definitions: opcodes, control-word bit positions and the
// decoded control words used by the controller/sequencer.
package sap_pkg;

    typedef logic [11:0] con_t;

    localparam int T_STATES = 6;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Bit positions in the control word; n* signals are active-low.
    localparam int CON_CP  = 11;
    localparam int CON_EP  = 10;
    localparam int CON_NLM = 9;
    localparam int CON_NCE = 8;
    localparam int CON_NLI = 7;
    localparam int CON_NEI = 6;
    localparam int CON_NLA = 5;
    localparam int CON_EA  = 4;
    localparam int CON_SU  = 3;
    localparam int CON_EU  = 2;
    localparam int CON_NLB = 1;
    localparam int CON_NLO = 0;

    localparam con_t CON_NOP    = 12'h3E3;
    localparam con_t CON_T1     = 12'h5E3;
    localparam con_t CON_T2     = 12'hBE3;
    localparam con_t CON_T3     = 12'h263;
    localparam con_t CON_LDA_T4 = 12'h1A3;
    localparam con_t CON_LDA_T5 = 12'h2C3;
    localparam con_t CON_ADD_T4 = 12'h1A3;
    localparam con_t CON_ADD_T5 = 12'h2E1;
    localparam con_t CON_ADD_T6 = 12'h3C7;
    localparam con_t CON_SUB_T6 = 12'h3CF;
    localparam con_t CON_OUT_T4 = 12'h3F2;

    function automatic logic is_defined(input logic [3:0] op);
        return (op == OP_LDA) || (op == OP_ADD) || (op == OP_SUB) ||
               (op == OP_OUT) || (op == OP_HLT);
    endfunction

endpackage

// File: rtl/ring_counter.sv
// One-hot ring counter with enable; any non-one-hot value returns to the
// first state on the next clock regardless of enable.
module ring_counter #(
    parameter int LEN = 6
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           enable,
    output logic [LEN-1:0] state
);

    logic legal;

    always_comb begin
        legal = (state != '0) && ((state & (state - LEN'(1))) == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= LEN'(1);
        end else if (!legal) begin
            state <= LEN'(1);
        end else if (enable) begin
            state <= {state[LEN-2:0], state[LEN-1]};
        end
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP control unit: T1..T6 ring plus opcode decode into the 12-bit control
// word; HLT freezes the ring at T5 until reset.
module controller_sequencer
    import sap_pkg::*;
#(
    parameter bit HALT_ON_UNKNOWN = 1'b0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  instruction,
    output logic [11:0] con,
    output logic [5:0]  t_state,
    output logic        halted
);

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    logic halt_op;

    always_comb begin
        halt_op = (instruction == OP_HLT) ||
                  (HALT_ON_UNKNOWN && !is_defined(instruction));
    end

    ring_counter #(.LEN(T_STATES)) u_ring (
        .clock  (clock),
        .reset  (reset),
        .enable (!halted),
        .state  (t_state)
    );

    // The ring steps T4->T5 on the same edge that sets halted, so it parks at T5.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            halted <= 1'b0;
        end else if (t_state == T4 && halt_op) begin
            halted <= 1'b1;
        end
    end

    // NOTE: con gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        con = CON_NOP;
        if (!halted) begin
            case (t_state)
                T1: con = CON_T1;
                T2: con = CON_T2;
                T3: con = CON_T3;
                T4: begin
                    case (instruction)
                        OP_LDA:  con = CON_LDA_T4;
                        OP_ADD:  con = CON_ADD_T4;
                        OP_SUB:  con = CON_ADD_T4;
                        OP_OUT:  con = CON_OUT_T4;
                        default: con = CON_NOP;
                    endcase
                end
                T5: begin
                    case (instruction)
                        OP_LDA:  con = CON_LDA_T5;
                        OP_ADD:  con = CON_ADD_T5;
                        OP_SUB:  con = CON_ADD_T5;
                        default: con = CON_NOP;
                    endcase
                end
                T6: begin
                    case (instruction)
                        OP_ADD:  con = CON_ADD_T6;
                        OP_SUB:  con = CON_SUB_T6;
                        default: con = CON_NOP;
                    endcase
                end
                default: con = CON_NOP;
            endcase
        end
    end

endmodule

// File: tb/tb_controller_sequencer.sv
// Self-checking bench for controller_sequencer: two instances (NOP and halt
// handling of undefined opcodes) checked against a step/halt model.
module tb_controller_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  instruction = 4'h0;
    logic [11:0] con0, con1;
    logic [5:0]  t0, t1;
    logic        h0, h1;

    int n_vec = 0;
    int n_err = 0;

    int m_step [2];
    bit m_halt [2];

    always #5 clock = ~clock;

    controller_sequencer #(.HALT_ON_UNKNOWN(1'b0)) dut_nop (
        .clock(clock), .reset(reset), .instruction(instruction),
        .con(con0), .t_state(t0), .halted(h0)
    );

    controller_sequencer #(.HALT_ON_UNKNOWN(1'b1)) dut_halt (
        .clock(clock), .reset(reset), .instruction(instruction),
        .con(con1), .t_state(t1), .halted(h1)
    );

    function automatic bit op_defined(input logic [3:0] op);
        return op inside {4'h0, 4'h1, 4'h2, 4'hE, 4'hF};
    endfunction

    function automatic bit op_halts(input logic [3:0] op, input int i);
        return (op == 4'hF) || (i == 1 && !op_defined(op));
    endfunction

    function automatic logic [11:0] exec_word(input logic [3:0] op, input int k);
        logic [11:0] w [3];
        case (op)
            4'h0:    w = '{12'h1A3, 12'h2C3, 12'h3E3};
            4'h1:    w = '{12'h1A3, 12'h2E1, 12'h3C7};
            4'h2:    w = '{12'h1A3, 12'h2E1, 12'h3CF};
            4'hE:    w = '{12'h3F2, 12'h3E3, 12'h3E3};
            default: w = '{12'h3E3, 12'h3E3, 12'h3E3};
        endcase
        return w[k];
    endfunction

    function automatic logic [18:0] expected(input int i);
        logic [11:0] fetch [3];
        logic [11:0] c;
        fetch = '{12'h5E3, 12'hBE3, 12'h263};
        if (m_halt[i])         c = 12'h3E3;
        else if (m_step[i] < 3) c = fetch[m_step[i]];
        else                    c = exec_word(instruction, m_step[i] - 3);
        return {c, 6'(1 << m_step[i]), m_halt[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_step[i] = 0;
            m_halt[i] = 1'b0;
        end
    endtask

    // One rising edge; the model steps with the instruction held across it.
    task automatic advance();
        @(posedge clock);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                if (!m_halt[i]) begin
                    if (m_step[i] == 3 && op_halts(instruction, i)) m_halt[i] = 1'b1;
                    m_step[i] = (m_step[i] + 1) % 6;
                end
            end
        end
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 6; k++) begin
            if (k == 3) reset = 1'b1;
            instruction = 4'($urandom);
            #1;
            n_vec++;
            if ({con0, t0, h0} !== expected(0) ||
                (k < 3 && {con0, t0, h0} !== {12'h5E3, 6'b000001, 1'b0})) begin
                n_err++;
                $display("FAIL reset[%0d] dut0: got %h/%b/%b want %h", k, con0, t0, h0, expected(0));
            end
            n_vec++;
            if ({con1, t1, h1} !== expected(1)) begin
                n_err++;
                $display("FAIL reset[%0d] dut1: got %h/%b/%b want %h", k, con1, t1, h1, expected(1));
            end
            advance();
            @(negedge clock);
        end
    endtask

    // Continues from T4 left by test_reset, then checks the wrap to T1.
    task automatic test_lda();
        for (int k = 0; k < 4; k++) begin
            instruction = 4'h0;
            #1;
            n_vec++;
            if ({con0, t0, h0} !== expected(0)) begin
                n_err++;
                $display("FAIL lda[%0d] dut0: got %h/%b/%b want %h", k, con0, t0, h0, expected(0));
            end
            n_vec++;
            if ({con1, t1, h1} !== expected(1)) begin
                n_err++;
                $display("FAIL lda[%0d] dut1: got %h/%b/%b want %h", k, con1, t1, h1, expected(1));
            end
            if (k < 3) advance();
            if (k < 3) @(negedge clock);
        end
    endtask

    task automatic test_add_sub();
        logic [3:0] ops [2];
        ops = '{4'h1, 4'h2};
        for (int n = 0; n < 2; n++) begin
            for (int k = 0; k < 6; k++) begin
                instruction = (k < 3) ? 4'($urandom) : ops[n];
                #1;
                n_vec++;
                if ({con0, t0, h0} !== expected(0)) begin
                    n_err++;
                    $display("FAIL add_sub op%0h[%0d] dut0: got %h/%b/%b want %h", ops[n], k, con0, t0, h0, expected(0));
                end
                n_vec++;
                if ({con1, t1, h1} !== expected(1)) begin
                    n_err++;
                    $display("FAIL add_sub op%0h[%0d] dut1: got %h/%b/%b want %h", ops[n], k, con1, t1, h1, expected(1));
                end
                advance();
                @(negedge clock);
            end
        end
    endtask

    task automatic test_out_hlt();
        for (int k = 0; k < 32; k++) begin
            if (k < 6)       instruction = (k < 3) ? 4'($urandom) : 4'hE;
            else if (k < 12) instruction = (k < 9) ? 4'($urandom) : 4'hF;
            else             instruction = 4'($urandom);
            #1;
            n_vec++;
            if ({con0, t0, h0} !== expected(0) ||
                (k >= 10 && {con0, t0, h0} !== {12'h3E3, 6'b010000, 1'b1})) begin
                n_err++;
                $display("FAIL out_hlt[%0d] dut0: got %h/%b/%b want %h", k, con0, t0, h0, expected(0));
            end
            n_vec++;
            if ({con1, t1, h1} !== expected(1)) begin
                n_err++;
                $display("FAIL out_hlt[%0d] dut1: got %h/%b/%b want %h", k, con1, t1, h1, expected(1));
            end
            advance();
            @(negedge clock);
        end
    endtask

    // Reset while halted, then reset during T5 of ADD, both between edges.
    task automatic test_mid_reset();
        for (int n = 0; n < 2; n++) begin
            if (n == 1) begin
                for (int k = 0; k < 4; k++) begin
                    instruction = (k < 3) ? 4'($urandom) : 4'h1;
                    advance();
                    @(negedge clock);
                end
                #1;
                n_vec++;
                if ({con0, t0} !== {12'h2E1, 6'b010000}) begin
                    n_err++;
                    $display("FAIL mid_reset pre dut0: got %h/%b want 2e1/010000", con0, t0);
                end
            end
            #2 reset = 1'b0;
            model_reset();
            #1;
            n_vec++;
            if ({con0, t0, h0} !== {12'h5E3, 6'b000001, 1'b0}) begin
                n_err++;
                $display("FAIL mid_reset[%0d] dut0: got %h/%b/%b want 5e3/000001/0", n, con0, t0, h0);
            end
            n_vec++;
            if ({con1, t1, h1} !== expected(1)) begin
                n_err++;
                $display("FAIL mid_reset[%0d] dut1: got %h/%b/%b want %h", n, con1, t1, h1, expected(1));
            end
            @(negedge clock);
            reset = 1'b1;
        end
    endtask

    task automatic test_undefined();
        for (int k = 0; k < 12; k++) begin
            if (k < 6) instruction = (k < 3) ? 4'($urandom) : 4'h7;
            else       instruction = (k < 9) ? 4'($urandom) : 4'h0;
            #1;
            n_vec++;
            if ({con0, t0, h0} !== expected(0)) begin
                n_err++;
                $display("FAIL undefined[%0d] dut0: got %h/%b/%b want %h", k, con0, t0, h0, expected(0));
            end
            n_vec++;
            if ({con1, t1, h1} !== expected(1) || (k >= 4 && h1 !== 1'b1)) begin
                n_err++;
                $display("FAIL undefined[%0d] dut1: got %h/%b/%b want %h", k, con1, t1, h1, expected(1));
            end
            advance();
            @(negedge clock);
        end
        reset_pulse();
    endtask

    task automatic test_random();
        logic [3:0] op;
        for (int n = 0; n < 40; n++) begin
            op = 4'($urandom_range(0, 15));
            for (int k = 0; k < 6; k++) begin
                instruction = (k < 3) ? 4'($urandom) : op;
                #1;
                n_vec++;
                if ({con0, t0, h0} !== expected(0) || (con0[10] && !con0[6])) begin
                    n_err++;
                    $display("FAIL random[%0d.%0d] dut0: got %h/%b/%b want %h", n, k, con0, t0, h0, expected(0));
                end
                n_vec++;
                if ({con1, t1, h1} !== expected(1)) begin
                    n_err++;
                    $display("FAIL random[%0d.%0d] dut1: got %h/%b/%b want %h", n, k, con1, t1, h1, expected(1));
                end
                advance();
                @(negedge clock);
            end
            if (m_halt[0] || (m_halt[1] && $urandom_range(0, 3) == 0)) reset_pulse();
        end
    endtask

    initial begin
        model_reset();
        @(negedge clock);
        test_reset();
        test_lda();
        test_add_sub();
        test_out_hlt();
        test_mid_reset();
        test_undefined();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
